// File: rtl/hero_pose_ctrl.sv
// Hero pose controller: debounced up/down buttons drive a timed pose code
// (0 stand, 1 up, 2 down) with a hold period followed by an anti-spam cooldown.

module hero_pose_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_prev_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      lvl_prev_q <= lvl_q;
      press_q    <= lvl_q & ~lvl_prev_q;
      // Any cycle where sync agrees with the accepted level restarts the count.
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= ~lvl_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module hero_pose_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int COOLDOWN_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] pose,
  output logic       busy,
  output logic       action_done,
  output logic [7:0] action_count
);
  localparam int TMAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  logic          up_press, dn_press;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pose_q, pose_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    count_q, count_d;

  hero_pose_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_up), .press_o(up_press)
  );

  hero_pose_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_down), .press_o(dn_press)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        // Simultaneous presses are ambiguous and both get dropped.
        if (up_press && !dn_press) begin
          state_d = S_UP;
          timer_d = TW'(HOLD_CYCLES - 1);
        end else if (dn_press && !up_press) begin
          state_d = S_DOWN;
          timer_d = TW'(HOLD_CYCLES - 1);
        end
      end
      S_UP, S_DOWN: begin
        if (timer_q == '0) begin
          state_d = S_COOL;
          timer_d = TW'(COOLDOWN_CYCLES - 1);
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_COOL: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
    endcase

    // Outputs are registered from the next state so they align with state_q.
    pose_d = (state_d == S_UP) ? 2'd1 : (state_d == S_DOWN) ? 2'd2 : 2'd0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pose_q  <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pose_q  <= pose_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign pose         = pose_q;
  assign busy         = busy_q;
  assign action_done  = done_q;
  assign action_count = count_q;
endmodule

// File: tb/tb_hero_pose_ctrl.sv
// Directed bench for hero_pose_ctrl with small timing parameters (4/10/5).

module tb_hero_pose_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] pose;
  logic       busy;
  logic       action_done;
  logic [7:0] action_count;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  hero_pose_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .COOLDOWN_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .pose(pose), .busy(busy), .action_done(action_done), .action_count(action_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (action_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  // Leaves us at posedge+1 with rst low; the next posedge is the first released edge.
  task automatic do_reset();
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pose",  pose, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  action_done, 0);
    chk("rst_count", action_count, 0);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;

    // 1: single up action
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      btn_up = (k <= 20);
      step();
      chk("t1_pose",  pose, (k >= 8 && k <= 17) ? 1 : 0);
      chk("t1_busy",  busy, (k >= 8 && k <= 22) ? 1 : 0);
      chk("t1_done",  action_done, (k == 18) ? 1 : 0);
      chk("t1_count", action_count, (k >= 18) ? 1 : 0);
    end
    chk("t1_pulses", done_cnt, 1);

    // 2: short glitches on down are rejected
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      btn_down = (k == 11) || (k >= 22 && k <= 23) || (k >= 34 && k <= 36);
      step();
      chk("t2_pose", pose, 0);
      chk("t2_busy", busy, 0);
    end
    chk("t2_count", action_count, 0);

    // 3: down presses during UP and during COOLDOWN are dropped
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      btn_up   = (k <= 12);
      btn_down = (k >= 4 && k <= 7) || (k >= 12 && k <= 17);
      step();
      chk("t3_pose", pose, (k >= 8 && k <= 17) ? 1 : 0);
      chk("t3_busy", busy, (k >= 8 && k <= 22) ? 1 : 0);
    end
    chk("t3_count", action_count, 1);

    // 4: simultaneous presses discarded, then a solo down works
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      btn_up   = (k <= 6);
      btn_down = (k <= 6);
      step();
      chk("t4_both_pose", pose, 0);
      chk("t4_both_busy", busy, 0);
    end
    btn_up = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      btn_down = (k <= 12);
      step();
      chk("t4_dn_pose", pose, (k >= 8 && k <= 17) ? 2 : 0);
      chk("t4_dn_done", action_done, (k == 18) ? 1 : 0);
    end
    chk("t4_count", action_count, 1);

    // 5: reset in the middle of DOWN, button still held
    for (int k = 1; k <= 30; k++) begin
      btn_down = 1'b1;
      rst      = (k == 12);
      step();
      chk("t5_pose", pose, ((k >= 8 && k <= 11) || (k >= 20 && k <= 29)) ? 2 : 0);
      if (k == 11) chk("t5_count_pre", action_count, 1);
      if (k == 12) begin
        chk("t5_busy_rst",  busy, 0);
        chk("t5_count_rst", action_count, 0);
      end
    end
    btn_down = 1'b0;
    repeat (20) step();

    // 6: 256 back-to-back up actions, counter wraps
    do_reset();
    base = done_cnt;
    for (int n = 1; n <= 256; n++) begin
      btn_up = 1'b1;
      for (int i = 0; i < 30 && pose !== 2'd1; i++) step();
      chk("t6_up", pose, 1);
      for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
      chk("t6_idle", busy, 0);
      btn_up = 1'b0;
      repeat (10) step();
      if (n == 255) chk("t6_count255", action_count, 255);
      if (n == 256) chk("t6_count256", action_count, 0);
    end
    chk("t6_pulses", done_cnt - base, 256);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hero_pose_ctrl.md
Name: hero_pose_ctrl

Overview:
- Upstream pose controller for the hero character in the 7-segment game.
- Turns the raw up/down push-buttons into a timed pose code: 0 = standing, 1 = up, 2 = down.
- The pose code drives the per_select input of the per-character glyph ROMs.
- Handles synchronisation, debounce, pose hold time and a cooldown that blocks button spamming.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a button level is accepted (≥2).
- HOLD_CYCLES, 12500000: number of cycles the pose stays 1 or 2 (≥1).
- COOLDOWN_CYCLES, 2500000: number of cycles spent at pose 0 after an action, during which presses are ignored (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_up  in  1  raw asynchronous up button, active-high
- btn_down  in  1  raw asynchronous down button, active-high
- pose  out  2  0 stand, 1 up, 2 down; value 3 never driven; feeds per_select
- busy  out  1  high whenever state ≠ IDLE
- action_done  out  1  one-cycle pulse when an UP/DOWN hold ends
- action_count  out  8  number of completed actions; wraps 255→0

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears all of the following to 0:
  - sync flops, debounce counters, debounced levels and edge registers
  - state (goes to IDLE), timer
  - pose, busy, action_done, action_count
- Reset mid-action aborts it immediately; pose is 0 on the first cycle after the reset edge.
- Synchroniser: two flops per button. Counting the edge that first samples a raw high as edge 1, the sync output is high after edge 2.
- Debounce, independent per button:
  - Counter increments each cycle while sync ≠ debounced level.
  - Counter clears to 0 whenever sync = debounced level.
  - After DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips and the counter clears.
- Press event: registered one-cycle pulse on a 0→1 transition of the debounced level. Release events produce no pulse.
- Latency: pose changes at edge DEBOUNCE_CYCLES+4 after the raw button is first sampled high.
- A button held high through reset release is treated as a fresh press and debounced normally.
- Glitches shorter than DEBOUNCE_CYCLES produce no press.
- FSM states: IDLE, UP, DOWN, COOLDOWN. pose is a registered function of state: UP→1, DOWN→2, otherwise 0.
- IDLE:
  - up_press alone → UP, timer = HOLD_CYCLES-1.
  - down_press alone → DOWN, timer = HOLD_CYCLES-1.
  - Both presses in the same cycle → stay IDLE; both are discarded.
- UP / DOWN:
  - Timer decrements each cycle. All presses are ignored and are not queued.
  - When timer = 0 → COOLDOWN, timer = COOLDOWN_CYCLES-1, action_done = 1 for exactly that one cycle, action_count increments.
  - pose is non-zero for exactly HOLD_CYCLES cycles.
- COOLDOWN:
  - Timer decrements each cycle; presses are ignored and dropped.
  - When timer = 0 → IDLE.
  - pose = 0 and busy = 1 for exactly COOLDOWN_CYCLES cycles.
- A press whose pulse lands on the first IDLE cycle after COOLDOWN is accepted.
- Timer width: clog2(max(HOLD_CYCLES, COOLDOWN_CYCLES)+1). Debounce counter width: clog2(DEBOUNCE_CYCLES+1).
- action_count: unsigned 8-bit, modulo 256.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, COOLDOWN_CYCLES=5.
1. Reset, then btn_up high for 20 cycles → pose=1 from edge 8 for exactly 10 cycles; action_done pulses once; pose=0 with busy=1 for 5 cycles; busy drops; action_count=1.
2. Glitch test: btn_down pulses of 1, 2 and 3 cycles, separated by 10 low cycles → pose stays 0, busy stays 0, action_count stays 0.
3. Up press, then btn_down pressed during UP and again during COOLDOWN → pose stays 1 for 10 cycles then 0; no DOWN occurs; action_count=1.
4. btn_up and btn_down rise on the same cycle → no action, pose=0, busy=0. A later solo btn_down → pose=2 for 10 cycles.
5. Assert rst for 1 cycle in the middle of DOWN → next cycle pose=0, busy=0, action_count=0. btn_down still held → new DOWN starts DEBOUNCE+4 edges after reset release.
6. Perform 256 back-to-back up actions → action_count reads 255 after the 255th action and 0 after the 256th; action_done pulse count equals 256.
